pss_sequence_gen: RTL and testbench

- Transmit-side counterpart of the PSS detection chain.
- Generates the 127-symbol NR PSS sequence d_PSS for a selected N_id_2 (38.211 7.4.2.2) as BPSK IQ samples on an AXI-stream master with backpressure.
- Feeds the SSB resource mapper / IFFT in the test transmitter and supplies loopback stimulus for the correlator/detector path.

---
 rtl/pss_sequence_gen.sv | 193 +++++++++++++++++++
 tb/tb_pss_sequence_gen.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pss_sequence_gen.sv
// ============================================================================
// Module   : pss_sequence_gen
// Purpose  : NR PSS d_PSS generator (BPSK IQ) on an AXI-stream master.
//            Periodic restarts enabled by PSS_SEQUENCE_GEN_PERIODIC_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pss_sequence_gen #(
  parameter int OUT_DW    = 32,
  parameter int AMPLITUDE = 2**(OUT_DW/2-2),
  parameter int PSS_LEN   = 127,
  parameter int PERIOD    = 38400
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic [1:0]        N_id_2_i,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  input  logic              m_axis_out_tready,
  output logic              m_axis_out_tlast,
  output logic [1:0]        N_id_2_o,
  output logic              busy_o,
  output logic              error_o,
  output logic              overrun_o
);

  localparam int              HALF   = OUT_DW / 2;
  localparam logic [6:0]      SEED   = 7'b1110110;
  localparam logic [6:0]      LAST   = 7'(PSS_LEN - 1);
  localparam logic [HALF-1:0] POS_A  = HALF'(AMPLITUDE);
  localparam logic [HALF-1:0] NEG_A  = HALF'(-AMPLITUDE);

  // Unsupported configurations elaborate nothing extra; they are caught by review.
  if (PSS_LEN != 127 || PERIOD < 2) begin : g_unsupported_params
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRELOAD = 2'd1,
    OUTPUT  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic [6:0] cnt_q, cnt_d;
  logic [1:0] id_q, id_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;
  logic       launch;
  logic [1:0] launch_id;
  logic [6:0] launch_m0;

`ifdef PSS_SEQUENCE_GEN_PERIODIC_EN
  localparam int PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  logic [PW-1:0] per_cnt_q, per_cnt_d;
  logic          armed_q, armed_d;
  logic          overrun_q, overrun_d;
  logic          per_tick;

  assign per_tick = armed_q && (per_cnt_q == PW'(PERIOD - 1));
`endif

  // Register holds x(i)..x(i+6) with bit k = x(i+k); one call advances i by one.
  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    return {s[4] ^ s[0], s[6:1]};
  endfunction

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    valid_d   = valid_q;
    error_d   = 1'b0;
    launch    = 1'b0;
    launch_id = N_id_2_i;
    launch_m0 = 7'd0;
`ifdef PSS_SEQUENCE_GEN_PERIODIC_EN
    per_cnt_d = armed_q ? (per_tick ? '0 : per_cnt_q + PW'(1)) : per_cnt_q;
    armed_d   = armed_q;
    overrun_d = per_tick && (state_q != IDLE);
`endif

    case (state_q)
      IDLE: begin
        if (start_i && (N_id_2_i != 2'd3)) begin
          launch = 1'b1;
`ifdef PSS_SEQUENCE_GEN_PERIODIC_EN
          armed_d   = 1'b1;
          per_cnt_d = '0;
`endif
        end else begin
          error_d = start_i;
`ifdef PSS_SEQUENCE_GEN_PERIODIC_EN
          if (per_tick) begin
            launch    = 1'b1;
            launch_id = id_q;
          end
`endif
        end
      end
      PRELOAD: begin
        lfsr_d = lfsr_step(lfsr_q);
        cnt_d  = cnt_q - 7'd1;
        if (cnt_q == 7'd1) begin
          state_d = OUTPUT;
          valid_d = 1'b1;
          cnt_d   = 7'd0;
        end
      end
      OUTPUT: begin
        if (m_axis_out_tready) begin
          lfsr_d = lfsr_step(lfsr_q);
          if (cnt_q == LAST) begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = 7'd0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (launch) begin
      case (launch_id)
        2'd1:    launch_m0 = 7'd43;
        2'd2:    launch_m0 = 7'd86;
        default: launch_m0 = 7'd0;
      endcase
      id_d   = launch_id;
      lfsr_d = SEED;
      if (launch_m0 == 7'd0) begin
        state_d = OUTPUT;
        valid_d = 1'b1;
        cnt_d   = 7'd0;
      end else begin
        state_d = PRELOAD;
        cnt_d   = launch_m0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED;
      cnt_q     <= 7'd0;
      id_q      <= 2'd0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
`ifdef PSS_SEQUENCE_GEN_PERIODIC_EN
      per_cnt_q <= '0;
      armed_q   <= 1'b0;
      overrun_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
`ifdef PSS_SEQUENCE_GEN_PERIODIC_EN
      per_cnt_q <= per_cnt_d;
      armed_q   <= armed_d;
      overrun_q <= overrun_d;
`endif
    end
  end

  // Output stage is gated by valid so the bus reads zero whenever idle.
  assign m_axis_out_tvalid = valid_q;
  assign m_axis_out_tlast  = valid_q && (cnt_q == LAST);
  assign m_axis_out_tdata  = valid_q ? {{HALF{1'b0}}, (lfsr_q[0] ? NEG_A : POS_A)} : '0;
  assign N_id_2_o          = id_q;
  assign busy_o            = (state_q != IDLE);
  assign error_o           = error_q;
`ifdef PSS_SEQUENCE_GEN_PERIODIC_EN
  assign overrun_o         = overrun_q;
`else
  assign overrun_o         = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pss_sequence_gen.sv
// ============================================================================
// Module   : tb_pss_sequence_gen
// Purpose  : Scoreboard bench for pss_sequence_gen (optionally periodic build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pss_sequence_gen;

  localparam int OUT_DW = 32;
  localparam int HALF   = OUT_DW / 2;
  localparam int AMP    = 2**(HALF-2);
`ifdef PSS_SEQUENCE_GEN_PERIODIC_EN
  localparam int PERIOD = 300;
`else
  localparam int PERIOD = 38400;
`endif

  logic              clk = 1'b0;
  logic              reset_ni = 1'b0;
  logic              start_i = 1'b0;
  logic [1:0]        n_id_i = 2'd0;
  logic              tready = 1'b0;
  logic [OUT_DW-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic [1:0]        n_id_o;
  logic              busy;
  logic              error;
  logic              overrun;

  int checks = 0;
  int failures = 0;
  int beats = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit rand_mode = 1'b0;
  bit ready_level = 1'b0;
  bit stall_pending = 1'b0;
  logic [OUT_DW:0] held;
  logic [OUT_DW:0] exp_q[$];
  bit xs[0:126];

  pss_sequence_gen #(
    .OUT_DW(OUT_DW), .AMPLITUDE(AMP), .PSS_LEN(127), .PERIOD(PERIOD)
  ) dut (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(start_i), .N_id_2_i(n_id_i),
    .m_axis_out_tdata(tdata), .m_axis_out_tvalid(tvalid),
    .m_axis_out_tready(tready), .m_axis_out_tlast(tlast),
    .N_id_2_o(n_id_o), .busy_o(busy), .error_o(error), .overrun_o(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    tready = rand_mode ? 1'($urandom_range(0, 1)) : ready_level;
  end

  // Golden value: d(n) = 1 - 2*x((n + 43*id) mod 127), imag 0, tlast on n=126.
  function automatic logic [OUT_DW:0] expected(input int id, input int n);
    int m;
    logic [HALF-1:0] re;
    m  = (n + 43 * id) % 127;
    re = xs[m] ? HALF'(-AMP) : HALF'(AMP);
    return {(n == 126), {HALF{1'b0}}, re};
  endfunction

  function automatic void push_expected(input int id);
    for (int n = 0; n < 127; n++) exp_q.push_back(expected(id, n));
  endfunction

  always @(negedge clk) begin
    if (!mon_en) begin
      stall_pending = 1'b0;
    end else if (tvalid) begin
      if (stall_pending) begin
        checks++;
        if ({tlast, tdata} !== held) begin
          failures++;
          $display("FAIL stall_hold: got %h required %h", {tlast, tdata}, held);
        end
      end
      if (tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat: got %h required no beat", {tlast, tdata});
        end else begin
          held = exp_q.pop_front();
          if ({tlast, tdata} !== held) begin
            failures++;
            $display("FAIL beat%0d: got %h required %h", beats, {tlast, tdata}, held);
          end
        end
        beats++;
        stall_pending = 1'b0;
      end else begin
        stall_pending = 1'b1;
        held = {tlast, tdata};
      end
    end
  end

  task automatic start_burst(input logic [1:0] id);
    @(posedge clk); #1;
    start_i = 1'b1;
    n_id_i  = id;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_beats(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (beats >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input bit level, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (tvalid === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({tvalid, tlast, busy, error, overrun} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 00000", {tvalid, tlast, busy, error, overrun});
    end
    checks++;
    if (tdata !== '0 || n_id_o !== 2'd0) begin
      failures++;
      $display("FAIL reset_data: got %h/%0d required 0/0", tdata, n_id_o);
    end
    @(posedge clk); #1;
    reset_ni = 1'b1;
    mon_en   = 1'b1;
  endtask

  task automatic test_burst(input logic [1:0] id, input bit random_ready);
    int lat;
    bit ok;
    rand_mode   = random_ready;
    ready_level = 1'b1;
    beats       = 0;
    push_expected(id);
    start_burst(id);
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (tvalid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      lat++;
    end
    checks++;
    if (!ok || lat != 1 + 43 * id) begin
      failures++;
      $display("FAIL latency_id%0d: got %0d required %0d", id, lat, 1 + 43 * id);
    end
    wait_beats(127, 2000, ok);
    checks++;
    if (!ok || beats != 127 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL beat_count_id%0d: got %0d left %0d required 127 left 0", id, beats, exp_q.size());
    end
    @(negedge clk); #1;
    checks++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || n_id_o !== id) begin
      failures++;
      $display("FAIL burst_end_id%0d: got v%b b%b id%0d required v0 b0 id%0d", id, tvalid, busy, n_id_o, id);
    end
    rand_mode = 1'b0;
  endtask

  task automatic test_error();
    logic [1:0] prev_id;
    prev_id = n_id_o;
    start_burst(2'd3);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || tvalid !== 1'b0) begin
      failures++;
      $display("FAIL error_pulse: got e%b b%b v%b required e1 b0 v0", error, busy, tvalid);
    end
    @(posedge clk); #1;
    checks++;
    if (error !== 1'b0 || busy !== 1'b0 || n_id_o !== prev_id) begin
      failures++;
      $display("FAIL error_clear: got e%b b%b id%0d required e0 b0 id%0d", error, busy, n_id_o, prev_id);
    end
  endtask

  task automatic test_start_during_burst();
    bit ok;
    bit err_seen;
    ready_level = 1'b1;
    beats       = 0;
    err_seen    = 1'b0;
    push_expected(0);
    start_burst(2'd0);
    repeat (20) @(posedge clk);
    #1;
    start_i = 1'b1;
    n_id_i  = 2'd1;
    @(posedge clk); #1;
    start_i = 1'b1;
    n_id_i  = 2'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (error === 1'b1) err_seen = 1'b1;
      if (beats >= 127) break;
    end
    wait_beats(127, 10, ok);
    checks++;
    if (!ok || err_seen || n_id_o !== 2'd0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL busy_start: got ok%b err%b id%0d left%0d required ok1 err0 id0 left0", ok, err_seen, n_id_o, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    ready_level = 1'b1;
    beats       = 0;
    push_expected(0);
    start_burst(2'd0);
    wait_beats(60, 200, ok);
    mon_en   = 1'b0;
    reset_ni = 1'b0;
    #1;
    checks++;
    if (!ok || tvalid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got ok%b v%b b%b required ok1 v0 b0", ok, tvalid, busy);
    end
    exp_q.delete();
    @(posedge clk); #1;
    reset_ni = 1'b1;
    mon_en   = 1'b1;
    test_burst(2'd0, 1'b0);
  endtask

`ifdef PSS_SEQUENCE_GEN_PERIODIC_EN
  task automatic test_periodic();
    int t1, t2, t3, t4, ovr;
    bit ok;
    ready_level = 1'b1;
    push_expected(1);
    push_expected(1);
    start_burst(2'd1);
    wait_valid(1'b1, 100, ok);
    t1 = cyc;
    wait_valid(1'b0, 300, ok);
    wait_valid(1'b1, 400, ok);
    t2 = cyc;
    checks++;
    if (!ok || t2 - t1 != PERIOD) begin
      failures++;
      $display("FAIL period: got %0d required %0d", t2 - t1, PERIOD);
    end
    push_expected(1);
    wait_valid(1'b0, 300, ok);
    wait_valid(1'b1, 400, ok);
    t3 = cyc;
    ready_level = 1'b0;
    ovr = 0;
    for (int i = 0; i < 350; i++) begin
      @(negedge clk); #1;
      if (overrun === 1'b1) ovr++;
    end
    checks++;
    if (ovr != 1 || tvalid !== 1'b1) begin
      failures++;
      $display("FAIL overrun: got %0d pulses v%b required 1 pulse v1", ovr, tvalid);
    end
    push_expected(1);
    ready_level = 1'b1;
    wait_valid(1'b0, 300, ok);
    wait_valid(1'b1, 600, ok);
    t4 = cyc;
    checks++;
    if (!ok || t4 - t3 != 2 * PERIOD) begin
      failures++;
      $display("FAIL skipped_burst: got %0d required %0d", t4 - t3, 2 * PERIOD);
    end
    wait_valid(1'b0, 300, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL periodic_drain: got %0d left required 0", exp_q.size());
    end
    mon_en   = 1'b0;
    reset_ni = 1'b0;
    @(posedge clk); #1;
    reset_ni = 1'b1;
  endtask
`endif

  initial begin
    logic [6:0] seed;
    seed = 7'b1110110;
    for (int i = 0; i < 7; i++) xs[i] = seed[i];
    for (int i = 0; i < 120; i++) xs[i+7] = xs[i+4] ^ xs[i];

    test_reset();
    test_burst(2'd0, 1'b0);
    test_burst(2'd1, 1'b0);
    test_burst(2'd2, 1'b0);
    test_burst(2'd2, 1'b1);
    test_error();
    test_start_during_burst();
    test_reset_mid_burst();
`ifdef PSS_SEQUENCE_GEN_PERIODIC_EN
    test_periodic();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
